// File: rtl/uart_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_frame_tx                                                              |
// | Sends a 5-byte 8N1 frame (AA, Less, Middle, Big, checksum) LSB first.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_frame_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] Less_in,
    input  logic [6:0] Middle_in,
    input  logic [6:0] Big_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int c_BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int c_CNT_W      = (c_BIT_CYCLES > 1) ? $clog2(c_BIT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_BIT_CYCLES - 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_START_BIT = 2'd1;
    localparam logic [1:0] c_DATA_BITS = 2'd2;
    localparam logic [1:0] c_STOP_BIT  = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         r_byte_idx;
    logic [6:0]         r_less;
    logic [6:0]         r_middle;
    logic [6:0]         r_big;
    logic               r_tx;
    logic               r_done;

    logic [7:0] w_sum;
    logic [7:0] w_byte;
    logic       w_bit_end;

    // Checksum covers the three data bytes only; the 8-bit add drops carries.
    assign w_sum     = {1'b0, r_less} + {1'b0, r_middle} + {1'b0, r_big};
    assign w_bit_end = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_byte = 8'hAA;
        case (r_byte_idx)
            3'd1:    w_byte = {1'b0, r_less};
            3'd2:    w_byte = {1'b0, r_middle};
            3'd3:    w_byte = {1'b0, r_big};
            3'd4:    w_byte = w_sum;
            default: w_byte = 8'hAA;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 3'd0;
            r_less     <= 7'd0;
            r_middle   <= 7'd0;
            r_big      <= 7'd0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != c_IDLE) begin
                r_cnt <= w_bit_end ? '0 : r_cnt + c_CNT_W'(1);
            end
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state    <= c_START_BIT;
                        r_cnt      <= '0;
                        r_bit_idx  <= 3'd0;
                        r_byte_idx <= 3'd0;
                        r_less     <= Less_in;
                        r_middle   <= Middle_in;
                        r_big      <= Big_in;
                        r_tx       <= 1'b0;
                    end
                end
                c_START_BIT: begin
                    if (w_bit_end) begin
                        r_state   <= c_DATA_BITS;
                        r_bit_idx <= 3'd0;
                        r_tx      <= w_byte[0];
                    end
                end
                c_DATA_BITS: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_STOP_BIT;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= w_byte[r_bit_idx + 3'd1];
                        end
                    end
                end
                default: begin
                    // Stop bit: chain straight into the next start bit, no idle gap.
                    if (w_bit_end) begin
                        if (r_byte_idx == 3'd4) begin
                            r_state <= c_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= c_START_BIT;
                            r_byte_idx <= r_byte_idx + 3'd1;
                            r_tx       <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = (r_state != c_IDLE);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_frame_tx                                                           |
// | Directed bench with a frame-position model and a serial line decoder.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_frame_tx;

    localparam int BC    = 16;
    localparam int FRAME = 50 * BC;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [6:0] less_in = 7'd0;
    logic [6:0] middle_in = 7'd0;
    logic [6:0] big_in = 7'd0;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_frame_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .Less_in   (less_in),
        .Middle_in (middle_in),
        .Big_in    (big_in),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: frame position counted from the accepting edge; line value by arithmetic.
    logic       m_active = 1'b0;
    logic       m_done = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_bytes [5];

    function automatic logic m_tx();
        int byte_i;
        int bit_i;
        if (!m_active) return 1'b1;
        byte_i = m_pos / (10 * BC);
        bit_i  = (m_pos % (10 * BC)) / BC;
        if (bit_i == 0) return 1'b0;
        if (bit_i == 9) return 1'b1;
        return m_bytes[byte_i][bit_i - 1];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_pos    <= 0;
        end else if (m_active) begin
            m_done <= 1'b0;
            if (m_pos == FRAME - 1) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end else begin
                m_pos <= m_pos + 1;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_active   <= 1'b1;
                m_pos      <= 0;
                m_bytes[0] <= 8'hAA;
                m_bytes[1] <= {1'b0, less_in};
                m_bytes[2] <= {1'b0, middle_in};
                m_bytes[3] <= {1'b0, big_in};
                m_bytes[4] <= 8'((int'(less_in) + int'(middle_in) + int'(big_in)) % 256);
            end
        end
    end

    // Per-cycle compare, statistics and an independent serial decoder.
    int         n_done = 0;
    int         n_busy = 0;
    int         cyc_cnt = 0;
    int         done_cyc = 0;
    logic       rx_on = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'd0;
    logic [7:0] rx_q [$];

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (!reset) begin
            rx_on <= 1'b0;
        end else begin
            chk("tx", {31'd0, tx}, {31'd0, m_tx()});
            chk("busy", {31'd0, busy}, {31'd0, m_active});
            chk("done", {31'd0, done}, {31'd0, m_done});
            if (done) begin
                n_done   <= n_done + 1;
                done_cyc <= cyc_cnt + 1;
            end
            if (busy) n_busy <= n_busy + 1;
            if (!rx_on) begin
                if (tx == 1'b0) begin
                    rx_on  <= 1'b1;
                    rx_cnt <= 1;
                end
            end else begin
                rx_cnt <= rx_cnt + 1;
                if (rx_cnt >= 8 + BC && rx_cnt <= 8 + 8 * BC && (rx_cnt - 8) % BC == 0)
                    rx_sh[(rx_cnt - 8) / BC - 1] <= tx;
                if (rx_cnt == 8 + 9 * BC) begin
                    rx_q.push_back(rx_sh);
                    rx_on <= 1'b0;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [6:0] l, input logic [6:0] m, input logic [6:0] b);
        less_in   = l;
        middle_in = m;
        big_in    = b;
        start     = 1'b1;
        cyc(1);
        start     = 1'b0;
    endtask

    task automatic wait_done_n(input int target, input int bound);
        int k = 0;
        while (n_done < target && k < bound) begin
            cyc(1);
            k++;
        end
        if (n_done < target) begin
            checks++;
            failures++;
            $display("FAIL timeout_done actual=%0d required=%0d", n_done, target);
        end
    endtask

    task automatic check_frame(input string nm, input int base,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3,
                               input logic [7:0] e4);
        logic [7:0] e [5];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        chk({nm, "_nbytes"}, 32'(rx_q.size() >= base + 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (base + i < rx_q.size())
                chk($sformatf("%s_byte%0d", nm, i), {24'd0, rx_q[base + i]}, {24'd0, e[i]});
        end
    endtask

    initial begin
        int d0;
        int b0;
        int q0;
        int c0;
        int gap;

        cyc(2);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        cyc(3);

        // Basic frame with latency and duration pinned by literals.
        d0 = n_done; b0 = n_busy; q0 = rx_q.size(); c0 = cyc_cnt;
        send(7'h12, 7'h34, 7'h56);
        wait_done_n(d0 + 1, 2000);
        cyc(3);
        chk("basic_done_cycle", 32'(done_cyc - c0), 32'd801);
        chk("basic_busy_cycles", 32'(n_busy - b0), 32'd800);
        chk("basic_done_pulses", 32'(n_done - d0), 32'd1);
        check_frame("basic", q0, 8'hAA, 8'h12, 8'h34, 8'h56, 8'h9C);

        // Checksum wrap.
        d0 = n_done; q0 = rx_q.size();
        send(7'h7F, 7'h7F, 7'h7F);
        wait_done_n(d0 + 1, 2000);
        cyc(3);
        check_frame("wrap", q0, 8'hAA, 8'h7F, 8'h7F, 8'h7F, 8'h7D);

        // Start and input changes while busy are ignored.
        d0 = n_done; q0 = rx_q.size();
        send(7'h12, 7'h34, 7'h56);
        cyc(98);
        send(7'h01, 7'h02, 7'h03);
        wait_done_n(d0 + 1, 2000);
        cyc(20);
        chk("reject_done_pulses", 32'(n_done - d0), 32'd1);
        chk("reject_frames", 32'(rx_q.size() - q0), 32'd5);
        check_frame("reject", q0, 8'hAA, 8'h12, 8'h34, 8'h56, 8'h9C);

        // Asynchronous reset mid-frame, then a clean frame.
        d0 = n_done;
        send(7'h11, 7'h22, 7'h33);
        cyc(299);
        #2 reset = 1'b0;
        #1;
        chk("midreset_tx", {31'd0, tx}, 32'd1);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        cyc(3);
        reset = 1'b1;
        cyc(20);
        chk("midreset_no_done", 32'(n_done - d0), 32'd0);
        chk("midreset_idle", {31'd0, busy}, 32'd0);
        q0 = rx_q.size();
        send(7'h05, 7'h0A, 7'h70);
        wait_done_n(d0 + 1, 2000);
        cyc(3);
        check_frame("after_reset", q0, 8'hAA, 8'h05, 8'h0A, 8'h70, 8'h7F);

        // Continuous start: two frames, one idle cycle between them.
        d0 = n_done; q0 = rx_q.size();
        less_in = 7'h01; middle_in = 7'h02; big_in = 7'h04;
        start = 1'b1;
        wait_done_n(d0 + 1, 2000);
        gap = 1;
        for (int k = 0; k < 50; k++) begin
            cyc(1);
            if (busy) break;
            gap++;
        end
        chk("cont_gap", 32'(gap), 32'd1);
        cyc(10);
        start = 1'b0;
        wait_done_n(d0 + 2, 2000);
        cyc(20);
        chk("cont_done_pulses", 32'(n_done - d0), 32'd2);
        check_frame("cont_f1", q0, 8'hAA, 8'h01, 8'h02, 8'h04, 8'h07);
        check_frame("cont_f2", q0 + 5, 8'hAA, 8'h01, 8'h02, 8'h04, 8'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate; BIT_CYCLES = CLK_FREQ/BAUD (integer division), 5208 at defaults.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to send one frame; sampled every clk edge.
REQ-006 Less_in  input  7  low field (seconds/day), BCD or binary, not interpreted.
REQ-007 Middle_in  input  7  middle field (minutes/month).
REQ-008 Big_in  input  7  high field (hours/year).
REQ-009 tx  output  1  serial line, idle high, 8N1, LSB first.
REQ-010 busy  output  1  high while a frame is in progress.
REQ-011 done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 The frame SHALL be 5 bytes, in order: header 8'hAA, {1'b0,Less}, {1'b0,Middle}, {1'b0,Big}, checksum.
REQ-013 The checksum SHALL be the 8-bit sum, modulo 256, of the three data bytes only (header excluded); carries are discarded.
REQ-014 Each byte SHALL be sent as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit held exactly BIT_CYCLES clocks.
REQ-015 Bytes SHALL be back-to-back: the next start bit follows the previous stop bit with no idle gap; one frame lasts exactly 50*BIT_CYCLES clocks.
REQ-016 FSM states SHALL be IDLE, START_BIT, DATA_BITS, STOP_BIT; a 3-bit byte index (0..4) and a 3-bit bit index (0..7) qualify the state.
REQ-017 IDLE -> START_BIT on a clk edge with start=1; Less_in, Middle_in and Big_in are latched on that edge and the checksum is computed from the latched values.
REQ-018 tx SHALL go low and busy SHALL go high on the clock edge that accepts start (1 cycle latency from start sample to line activity).
REQ-019 START_BIT -> DATA_BITS after BIT_CYCLES; DATA_BITS -> STOP_BIT after 8 bit periods; STOP_BIT -> START_BIT (byte index+1) after BIT_CYCLES if byte index < 4, else -> IDLE.
REQ-020 On the STOP_BIT -> IDLE transition busy SHALL go low and done SHALL be high for exactly that one following cycle; tx stays high.
REQ-021 start while busy=1 SHALL be ignored and not queued; input changes during a frame SHALL NOT affect the frame.
REQ-022 start=1 in the cycle done=1 (busy=0) SHALL be accepted, giving a new frame with one idle-high cycle between frames.
REQ-023 start held high continuously SHALL produce consecutive frames separated by one idle cycle.
REQ-024 The bit-period counter SHALL be wide enough for BIT_CYCLES-1 (13 bits at defaults) and SHALL reload on every bit boundary without drift.

Reset
REQ-025 reset=0 SHALL immediately force tx=1, busy=0, done=0, state IDLE, all counters and latched fields 0, independent of clk.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no done pulse; after release the block waits in IDLE for a new start.
REQ-027 The first start accepted is the first start sampled high on a clk edge with reset=1.

Verification (bench with CLK_FREQ=16, BAUD=1, BIT_CYCLES=16)
REQ-028 Basic frame: Less=7'h12, Middle=7'h34, Big=7'h56, start pulse -> tx decodes AA 12 34 56 9C; busy high 800 cycles; single done pulse at cycle 801.
REQ-029 Checksum wrap: Less=Middle=Big=7'h7F -> bytes AA 7F 7F 7F 7D.
REQ-030 Bit timing: each bit of the first byte measured at exactly 16 clocks; no gap between stop bit of byte n and start bit of byte n+1.
REQ-031 Busy rejection: second start at cycle 100 with different inputs -> still exactly one frame with the originally latched values, one done pulse.
REQ-032 Reset mid-frame: reset=0 at cycle 300 -> tx=1, busy=0 asynchronously, no done; a new start after release yields a complete correct frame.
REQ-033 Continuous start: start held high for two frames -> two identical frames, exactly one idle-high cycle between them, two done pulses.
